highway_road_controller: RTL
============================

Name: highway_road_controller

Overview:
- Highway-side FSM of the highway/country-road crossing; pairs with the country-road controller.
- Highway green is the default. The highway yields to the country road when a car is sensed and the minimum green has elapsed.
- Grants the country road with `enable_c`. Resumes highway green on `enable_h` from the country controller.
- Also hosts the country-road phase timer: consumes `start_c`, produces `time_out_c` for the country green and yellow phases.

Parameters:
- GREEN_MIN, 8, minimum highway green duration in clk cycles (>=1)
- YELLOW_T, 3, highway yellow duration in clk cycles (>=1)
- COUNTRY_GREEN, 6, country green duration in clk cycles (>=1)
- COUNTRY_YELLOW, 3, country yellow duration in clk cycles (>=1)
- CNT_W, 8, counter width; every duration parameter must be <= 2^CNT_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- car_sensor  input  1  level; 1 = vehicle waiting on country road; synchronous to clk
- enable_h  input  1  one-cycle pulse from country controller; country road has gone red
- start_c  input  1  one-cycle pulse from country controller; country green started, start country timer
- hw_light  output  3  one-hot highway lamp: 3'b100 green, 3'b010 yellow, 3'b001 red
- enable_c  output  1  one-cycle grant pulse to country controller
- time_out_c  output  1  one-cycle pulse; current country phase expired

Behaviour:
- Reset (rst_n=0, async), held until release:
  - state=HG, hw_light=3'b100, highway counter=GREEN_MIN-1, enable_c=0
  - country timer idle, time_out_c=0
- Highway FSM states HG, HY, HR; hw_light is a Moore output of the state.
- HG (highway green):
  - Counter decrements by 1 per cycle, saturating at 0.
  - On the edge where counter==0 and car_sensor==1: go to HY and load counter=YELLOW_T-1.
  - With car_sensor held 1 from the start, HG lasts exactly GREEN_MIN cycles.
  - A car arriving after the minimum has elapsed causes a transition on the first edge car_sensor is sampled 1.
  - A car_sensor pulse that drops before the minimum has elapsed is not remembered.
- HY (highway yellow):
  - Counter decrements each cycle.
  - On the edge where counter==0: go to HR.
  - HY lasts exactly YELLOW_T cycles; car_sensor is ignored.
- HR (highway red):
  - enable_c=1 during the first HR cycle only, registered and glitch-free. It is 0 in every other cycle.
  - On the edge where enable_h==1: go to HG and load counter=GREEN_MIN-1.
  - enable_h is accepted in any HR cycle, including the first (enable_c cycle).
  - enable_h in HG or HY is ignored, with no effect and no queuing.
- Country timer: states IDLE, CG, CY; counter width CNT_W, independent of the highway counter.
  - IDLE: on the edge where start_c==1, go to CG and load count=COUNTRY_GREEN-1.
  - CG or CY: count decrements each cycle.
  - time_out_c = (state!=IDLE) && count==0. It is a Moore output, high for exactly one cycle.
  - On that edge, CG goes to CY with count=COUNTRY_YELLOW-1, and CY goes to IDLE.
  - time_out_c therefore rises COUNTRY_GREEN cycles after the start_c edge, then again COUNTRY_YELLOW cycles later.
  - start_c while in CG or CY is ignored; the timer is not restarted.
- Simultaneous events:
  - Both FSMs advance on the same edge independently.
  - enable_h and start_c in the same cycle are each handled by their own FSM.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight enable_c or time_out_c pulse is cut.
- No state is reachable with hw_light not one-hot. An illegal state encoding recovers to HG on the next edge.

Test Plan:
- Reset release with car_sensor=1 constantly, defaults:
  - hw_light=100 for cycles 0-7, 010 for cycles 8-10, 001 from cycle 11.
  - enable_c=1 only in cycle 11.
- car_sensor=0 for 30 cycles after reset, then 1 for one cycle at cycle 30:
  - hw_light stays 100 through cycle 30 and goes 010 at cycle 31.
  - A car_sensor pulse at cycle 3 alone causes no transition.
- In HR, drive enable_h at the 5th HR cycle:
  - hw_light=100 next cycle; counter reloaded.
  - A new car needs the full 8 green cycles before the next yellow.
  - enable_h pulses injected during HG/HY change nothing.
- start_c pulse at cycle T:
  - time_out_c=1 at cycle T+6 and T+9 only.
  - A second start_c at T+3 is ignored (same pulse times); start_c at T+10 restarts the sequence.
- Closed loop with the country-road controller model: 3 full cycles complete.
  - Lights are never simultaneously green on both roads.
  - Every enable_c is followed by start_c, and every enable_h returns hw_light to 100.
- Assert rst_n=0 during HY and during timer phase CG:
  - Outputs go immediately to 100 / enable_c=0 / time_out_c=0.
  - After release, the behaviour matches the first scenario exactly.

Source files
------------

// File: rtl/highway_road_controller.sv
// highway_road_controller
//   Highway-side controller of the highway/country-road crossing. Highway
//   green is the default; the highway yields to a waiting country car once
//   the minimum green has elapsed, grants the country road with a one-cycle
//   enable_c_o pulse, and returns to green on enable_h_i. It also hosts the
//   country-road phase timer (start_c_i in, time_out_c_o out).
//
//   Highway FSM
//     state | meaning
//     HG    | highway green, minimum-green countdown, waits for a car
//     HY    | highway yellow, fixed duration
//     HR    | highway red, country road owns the crossing until enable_h_i
//
//   Country timer FSM
//     state  | meaning
//     C_IDLE | no country phase being timed
//     C_CG   | timing country green
//     C_CY   | timing country yellow
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   car_sensor_i level, vehicle waiting on the country road
//   enable_h_i   pulse, country road has gone red
//   start_c_i    pulse, country green started
//   hw_light_o   one-hot highway lamp {green, yellow, red}
//   enable_c_o   one-cycle grant pulse to the country controller
//   time_out_c_o one-cycle pulse, current country phase expired
module highway_road_controller #(
  parameter int GREEN_MIN      = 8,
  parameter int YELLOW_T       = 3,
  parameter int COUNTRY_GREEN  = 6,
  parameter int COUNTRY_YELLOW = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_sensor_i,
  input  logic       enable_h_i,
  input  logic       start_c_i,
  output logic [2:0] hw_light_o,
  output logic       enable_c_o,
  output logic       time_out_c_o
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] CG_LD     = CNT_W'(COUNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] CY_LD     = CNT_W'(COUNTRY_YELLOW - 1);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    HR = 2'b10
  } hw_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'b00,
    C_CG   = 2'b01,
    C_CY   = 2'b10
  } c_state_e;

  hw_state_e        hw_state_q, hw_state_d;
  logic [CNT_W-1:0] hw_cnt_q, hw_cnt_d;
  logic             enable_c_q, enable_c_d;

  c_state_e         c_state_q, c_state_d;
  logic [CNT_W-1:0] c_cnt_q, c_cnt_d;

  // ---------------- highway FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_state_q <= HG;
      hw_cnt_q   <= GREEN_LD;
      enable_c_q <= 1'b0;
    end else begin
      hw_state_q <= hw_state_d;
      hw_cnt_q   <= hw_cnt_d;
      enable_c_q <= enable_c_d;
    end
  end

  always_comb begin
    hw_state_d = hw_state_q;
    hw_cnt_d   = hw_cnt_q;
    enable_c_d = 1'b0;
    unique case (hw_state_q)
      HG: begin
        if (hw_cnt_q == '0) begin
          // Counter saturates at zero; a car arriving later switches at once.
          if (car_sensor_i) begin
            hw_state_d = HY;
            hw_cnt_d   = YELLOW_LD;
          end
        end else begin
          hw_cnt_d = hw_cnt_q - 1'b1;
        end
      end
      HY: begin
        if (hw_cnt_q == '0) begin
          hw_state_d = HR;
          // Grant is registered so it is high exactly in the first HR cycle.
          enable_c_d = 1'b1;
        end else begin
          hw_cnt_d = hw_cnt_q - 1'b1;
        end
      end
      HR: begin
        if (enable_h_i) begin
          hw_state_d = HG;
          hw_cnt_d   = GREEN_LD;
        end
      end
      default: begin
        hw_state_d = HG;
        hw_cnt_d   = GREEN_LD;
      end
    endcase
  end

  always_comb begin
    hw_light_o = 3'b100;
    unique case (hw_state_q)
      HG:      hw_light_o = 3'b100;
      HY:      hw_light_o = 3'b010;
      HR:      hw_light_o = 3'b001;
      default: hw_light_o = 3'b100;
    endcase
  end

  assign enable_c_o = enable_c_q;

  // ---------------- country phase timer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state_q <= C_IDLE;
      c_cnt_q   <= '0;
    end else begin
      c_state_q <= c_state_d;
      c_cnt_q   <= c_cnt_d;
    end
  end

  always_comb begin
    c_state_d = c_state_q;
    c_cnt_d   = c_cnt_q;
    unique case (c_state_q)
      C_IDLE: begin
        if (start_c_i) begin
          c_state_d = C_CG;
          c_cnt_d   = CG_LD;
        end
      end
      C_CG: begin
        if (c_cnt_q == '0) begin
          c_state_d = C_CY;
          c_cnt_d   = CY_LD;
        end else begin
          c_cnt_d = c_cnt_q - 1'b1;
        end
      end
      C_CY: begin
        if (c_cnt_q == '0) begin
          c_state_d = C_IDLE;
        end else begin
          c_cnt_d = c_cnt_q - 1'b1;
        end
      end
      default: begin
        c_state_d = C_IDLE;
        c_cnt_d   = '0;
      end
    endcase
  end

  assign time_out_c_o = ((c_state_q == C_CG) || (c_state_q == C_CY)) && (c_cnt_q == '0);

endmodule
